// File: rtl/median_pkg.sv
// Shared types for the MEDIAN window feeder: FSM states, burst length and burst index type.
package median_pkg;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    SEND   = 2'd1,
    WAIT   = 2'd2
  } feeder_state_t;

  localparam int WIN_N = 9;

  typedef logic [3:0] win_idx_t;

endpackage

// File: rtl/median_line_buffer.sv
// Two-line pixel history: combinational read of {L1[c], L0[c]}, shift-down write on each accept.
module median_line_buffer #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 16,
  parameter int COL_W = $clog2(IMG_W)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [COL_W-1:0] i_addr,
  input  logic [WIDTH-1:0] i_pix,
  output logic [WIDTH-1:0] o_l1,
  output logic [WIDTH-1:0] o_l0
);

  logic [WIDTH-1:0] r_line0 [IMG_W];
  logic [WIDTH-1:0] r_line1 [IMG_W];

  assign o_l1 = r_line1[i_addr];
  assign o_l0 = r_line0[i_addr];

  // Line storage is data only and carries no reset; unwritten entries are never consumed.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_line1[i_addr] <= r_line0[i_addr];
      r_line0[i_addr] <= i_pix;
    end
  end

endmodule

// File: rtl/median_window_feeder.sv
// Raster-to-3x3 window feeder: bursts each complete window to MEDIAN and republishes its result.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] PIX_IN,
  input  logic             PIX_VALID,
  input  logic             PIX_SOF,
  output logic             PIX_READY,
  output logic [WIDTH-1:0] DI,
  output logic             DSI,
  input  logic [WIDTH-1:0] DO,
  input  logic             DSO,
  output logic [WIDTH-1:0] RES,
  output logic             RES_VALID
);

  localparam int COL_W = $clog2(IMG_W);

  feeder_state_t    r_state, w_state_next;
  win_idx_t         r_k, w_k_next;
  logic [COL_W-1:0] r_col, w_col_eff;
  logic [1:0]       r_row, w_row_eff;
  logic             r_row_ge2, w_ge2_eff;
  logic             w_accept, w_complete, w_dsi_next, w_dso_take;
  logic [WIDTH-1:0] w_di_next, w_l1, w_l0;
  logic [WIDTH-1:0] r_win      [WIN_N];
  logic [WIDTH-1:0] w_win_next [WIN_N];

  assign PIX_READY = (r_state == ACCEPT) & ~RST;
  assign w_accept  = PIX_VALID & PIX_READY;

  median_line_buffer #(.WIDTH(WIDTH), .IMG_W(IMG_W), .COL_W(COL_W)) u_lines (
    .i_clk  (CLK),
    .i_we   (w_accept),
    .i_addr (w_col_eff),
    .i_pix  (PIX_IN),
    .o_l1   (w_l1),
    .o_l0   (w_l0)
  );

  // SOF restarts position tracking on the pixel itself, so it can never complete a window.
  always_comb begin
    w_col_eff  = PIX_SOF ? {COL_W{1'b0}} : r_col;
    w_row_eff  = PIX_SOF ? 2'd0 : r_row;
    w_ge2_eff  = PIX_SOF ? 1'b0 : r_row_ge2;
    w_complete = w_accept & w_ge2_eff & (w_col_eff >= COL_W'(2));
  end

  // Column/row position; row saturates at 2 since only row_ge2 is ever consulted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_col     <= {COL_W{1'b0}};
      r_row     <= 2'd0;
      r_row_ge2 <= 1'b0;
    end else if (w_accept) begin
      if (w_col_eff == COL_W'(IMG_W - 1)) begin
        r_col     <= {COL_W{1'b0}};
        r_row     <= (w_row_eff == 2'd2) ? 2'd2 : w_row_eff + 2'd1;
        r_row_ge2 <= w_ge2_eff | (w_row_eff >= 2'd1);
      end else begin
        r_col     <= w_col_eff + COL_W'(1);
        r_row     <= w_row_eff;
        r_row_ge2 <= w_ge2_eff;
      end
    end else begin
      r_col     <= r_col;
      r_row     <= r_row;
      r_row_ge2 <= r_row_ge2;
    end
  end

  // Next window: shift left and append the new column {L1, L0, PIX_IN} on the right.
  always_comb begin
    w_win_next = r_win;
    if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        w_win_next[r*3]     = r_win[r*3+1];
        w_win_next[r*3 + 1] = r_win[r*3+2];
      end
      w_win_next[2] = w_l1;
      w_win_next[5] = w_l0;
      w_win_next[8] = PIX_IN;
    end else begin
      w_win_next = r_win;
    end
  end

  // Window registers are pure data and need no reset.
  always_ff @(posedge CLK) begin
    r_win <= w_win_next;
  end

  // FSM next-state and the values the registered burst outputs will take.
  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    case (r_state)
      ACCEPT: begin
        if (w_complete) begin
          w_state_next = SEND;
          w_k_next     = 4'd0;
        end else begin
          w_state_next = ACCEPT;
        end
      end
      SEND: begin
        if (r_k == 4'(WIN_N - 1)) begin
          w_state_next = WAIT;
          w_k_next     = 4'd0;
        end else begin
          w_k_next = r_k + 4'd1;
        end
      end
      WAIT: begin
        if (DSO) begin
          w_state_next = ACCEPT;
        end else begin
          w_state_next = WAIT;
        end
      end
      default: begin
        w_state_next = ACCEPT;
        w_k_next     = 4'd0;
      end
    endcase
    w_dsi_next = (w_state_next == SEND);
    w_di_next  = w_dsi_next ? w_win_next[w_k_next] : {WIDTH{1'b0}};
    w_dso_take = (r_state == WAIT) & DSO;
  end

  // State and all registered outputs; reset aborts any burst in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ACCEPT;
      r_k       <= 4'd0;
      DSI       <= 1'b0;
      DI        <= {WIDTH{1'b0}};
      RES       <= {WIDTH{1'b0}};
      RES_VALID <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_k       <= w_k_next;
      DSI       <= w_dsi_next;
      DI        <= w_di_next;
      RES_VALID <= w_dso_take;
      if (w_dso_take) begin
        RES <= DO;
      end else begin
        RES <= RES;
      end
    end
  end

endmodule
